// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encodings and default width for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - combinational 1-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - LSB-first bit-serial adder sharing one full_adder cell
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New bit enters at the MSB; for WIDTH=1 this degenerates to fa_sum.
  assign sum_next = WIDTH'({fa_sum, sum_sh} >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            state <= ST_SHIFT;
            ready <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_cout;
          // Counter stops at LAST so it never wraps inside SHIFT.
          if (cnt == LAST) begin
            sum_out  <= sum_next;
            cout_out <= fa_cout;
            state    <= ST_DONE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst8, start8, cin8, ready8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       rst1, start1, cin1, ready1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8), .start(start8), .ready(ready8),
    .a_in(a8), .b_in(b8), .cin(cin8), .busy(busy8), .done(done8),
    .sum_out(sum8), .cout_out(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst1), .start(start1), .ready(ready1),
    .a_in(a1), .b_in(b1), .cin(cin1), .busy(busy1), .done(done1),
    .sum_out(sum1), .cout_out(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run8(input vec_t v, input int idx);
    int edges;
    @(negedge clk);
    a8 = v.a; b8 = v.b; cin8 = v.cin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    edges = 1;
    check($sformatf("vec%0d busy", idx), 64'(busy8), 64'd1);
    while (!done8 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check($sformatf("vec%0d latency", idx), 64'(edges), 64'd9);
    check($sformatf("vec%0d sum", idx), 64'(sum8), 64'(v.sum));
    check($sformatf("vec%0d cout", idx), 64'(cout8), 64'(v.cout));
    @(negedge clk);
    check($sformatf("vec%0d done pulse", idx), 64'({done8, ready8}), 64'b01);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int edges, pulses;
    logic [7:0] seen_sum;
    logic       seen_cout;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};

    rst8 = 1'b0; start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b1;
    rst1 = 1'b0; start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready/busy/done", 64'({ready8, busy8, done8}), 64'b100);
    check("reset sum", 64'(sum8), 64'd0);
    check("reset cout", 64'(cout8), 64'd0);
    check("reset w1 ready/busy/done", 64'({ready1, busy1, done1}), 64'b100);
    rst8 = 1'b1; rst1 = 1'b1;

    for (int i = 0; i < 7; i++) run8(vecs[i], i);

    // start while busy must be ignored
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h55; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0; seen_sum = 8'hEE; seen_cout = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done8) begin
        pulses++;
        seen_sum  = sum8;
        seen_cout = cout8;
      end
    end
    check("busy-start done count", 64'(pulses), 64'd1);
    check("busy-start sum", 64'(seen_sum), 64'h10);
    check("busy-start cout", 64'(seen_cout), 64'd0);

    // reset mid-SHIFT, with start asserted on the same edge
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    check("abort ready/busy/done", 64'({ready8, busy8, done8}), 64'b100);
    check("abort sum", 64'(sum8), 64'd0);
    check("abort cout", 64'(cout8), 64'd0);
    rst8 = 1'b1; start8 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    check("abort no done", 64'(pulses), 64'd0);

    // start held high: back-to-back adds, second accepted during DONE
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55;
    edges = 1;
    while (!done8 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("b2b first latency", 64'(edges), 64'd9);
    check("b2b first sum", 64'({cout8, sum8}), 64'h010);
    check("b2b ready in done", 64'(ready8), 64'd1);
    @(negedge clk);
    edges = 1;
    check("b2b re-accept busy/done", 64'({busy8, done8}), 64'b10);
    check("b2b sum held", 64'(sum8), 64'h10);
    while (!done8 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("b2b spacing", 64'(edges), 64'd9);
    check("b2b second sum", 64'({cout8, sum8}), 64'h0FF);
    start8 = 1'b0;
    @(negedge clk);
    check("b2b idle", 64'({ready8, busy8, done8}), 64'b100);

    // WIDTH=1: every (a,b,cin) combination
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int exp_val;
      v = 3'(i);
      exp_val = int'(v[2]) + int'(v[1]) + int'(v[0]);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
      edges = 1;
      while (!done1 && edges < 10) begin
        @(negedge clk);
        edges++;
      end
      check($sformatf("w1 combo%0d latency", i), 64'(edges), 64'd2);
      check($sformatf("w1 combo%0d result", i), 64'({cout1, sum1}), 64'(exp_val));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
